// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle logic/arith ops plus iterative signed
// multiply and divide behind a start/busy/done handshake.
module alu_multicycle #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] hi_o,
  output logic              zero_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0]   W_ZERO   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0]   W_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [2*DATA_W-1:0] DW_ONE   = {{(2*DATA_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SGT = 4'b1000;
  localparam logic [3:0] OP_SNE = 4'b1111;
  localparam logic [3:0] OP_GEZ = 4'b1010;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return ~v + W_ONE;
  endfunction

  function automatic logic [DATA_W-1:0] mag_w(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? neg_w(v) : v;
  endfunction

  function automatic logic [DATA_W-1:0] bool_w(input logic b);
    return {{(DATA_W-1){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] simple_op(input logic [3:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = bool_w($signed(a) < $signed(b));
      OP_SGT:  r = bool_w($signed(a) > $signed(b));
      OP_SNE:  r = bool_w(a != b);
      OP_GEZ:  r = bool_w(~a[DATA_W-1]);
      OP_LUI:  r = b << (DATA_W / 2);
      OP_SLL:  r = b << a[SH_W-1:0];
      default: r = a + b;
    endcase
    return r;
  endfunction

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   a_mag_q, b_mag_q;
  logic [2*DATA_W-1:0] p_q;
  logic                neg_lo_q, neg_hi_q, is_mul_q;
  logic                busy_q, done_q, zero_q;
  logic [DATA_W-1:0]   result_q, hi_q;

  logic [DATA_W-1:0]   simple_res_d;
  logic [DATA_W:0]     mul_sum_d, rem_sh_d;
  logic                rem_ge_d;
  logic [DATA_W-1:0]   rem_d, fix_lo_d, fix_hi_d;
  logic [2*DATA_W-1:0] step_d, prod_d;

  // Single-cycle result, one shift-add / restoring step, and final sign fix-up.
  always_comb begin
    simple_res_d = simple_op(ALUCtrl_i, src1_i, src2_i);
    mul_sum_d = {1'b0, p_q[2*DATA_W-1:DATA_W]}
              + (p_q[0] ? {1'b0, a_mag_q} : {(DATA_W+1){1'b0}});
    // p_q holds {partial remainder, dividend bits still to shift in / quotient bits}
    rem_sh_d = {p_q[2*DATA_W-1:DATA_W], p_q[DATA_W-1]};
    rem_ge_d = (rem_sh_d >= {1'b0, b_mag_q});
    if (rem_ge_d) begin
      rem_d = rem_sh_d[DATA_W-1:0] - b_mag_q;
    end else begin
      rem_d = rem_sh_d[DATA_W-1:0];
    end
    if (state_q == S_MUL) begin
      step_d = {mul_sum_d, p_q[DATA_W-1:1]};
    end else begin
      step_d = {rem_d, p_q[DATA_W-2:0], rem_ge_d};
    end
    prod_d = neg_lo_q ? (~p_q + DW_ONE) : p_q;
    if (is_mul_q) begin
      fix_lo_d = prod_d[DATA_W-1:0];
      fix_hi_d = prod_d[2*DATA_W-1:DATA_W];
    end else begin
      fix_lo_d = neg_lo_q ? neg_w(p_q[DATA_W-1:0]) : p_q[DATA_W-1:0];
      fix_hi_d = neg_hi_q ? neg_w(p_q[2*DATA_W-1:DATA_W]) : p_q[2*DATA_W-1:DATA_W];
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_mag_q  <= W_ZERO;
      b_mag_q  <= W_ZERO;
      p_q      <= {(2*DATA_W){1'b0}};
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_mul_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= W_ZERO;
      hi_q     <= W_ZERO;
      zero_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              a_mag_q  <= mag_w(src1_i);
              b_mag_q  <= mag_w(src2_i);
              p_q      <= {W_ZERO, mag_w(src2_i)};
              neg_lo_q <= src1_i[DATA_W-1] ^ src2_i[DATA_W-1];
              is_mul_q <= 1'b1;
              cnt_q    <= {CNT_W{1'b0}};
              busy_q   <= 1'b1;
              state_q  <= S_MUL;
            end else if (ALUCtrl_i == OP_DIV && src2_i != W_ZERO) begin
              b_mag_q  <= mag_w(src2_i);
              p_q      <= {W_ZERO, mag_w(src1_i)};
              neg_lo_q <= src1_i[DATA_W-1] ^ src2_i[DATA_W-1];
              neg_hi_q <= src1_i[DATA_W-1];
              is_mul_q <= 1'b0;
              cnt_q    <= {CNT_W{1'b0}};
              busy_q   <= 1'b1;
              state_q  <= S_DIV;
            end else if (ALUCtrl_i == OP_DIV) begin
              result_q <= {DATA_W{1'b1}};
              hi_q     <= src1_i;
              zero_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              result_q <= simple_res_d;
              zero_q   <= (simple_res_d == W_ZERO);
              done_q   <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          p_q <= step_d;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_FIX: begin
          result_q <= fix_lo_d;
          hi_q     <= fix_hi_d;
          zero_q   <= (fix_lo_d == W_ZERO);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign hi_o     = hi_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and model-checked stimulus for alu_multicycle at DATA_W=32.
module tb_alu_multicycle;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] src1, src2;
  logic        busy, done, zero;
  logic [31:0] result, hi;

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(.DATA_W(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ALUCtrl_i (ctrl),
    .src1_i    (src1),
    .src2_i    (src2),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .hi_o      (hi),
    .zero_o    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, track busy, and check latency, results and the done pulse.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic [31:0] exp_hi, input string tag, input bit poke);
    int lat;
    int nbusy;
    ctrl = op; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src1 = $urandom; src2 = $urandom;
    lat = 1; nbusy = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) nbusy++;
      if (poke && lat == 5) begin
        start = 1'b1; ctrl = 4'b0010;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check_eq({tag, ":lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, ":res"}, {32'h0, result}, {32'h0, exp_res});
    check_eq({tag, ":hi"}, {32'h0, hi}, {32'h0, exp_hi});
    check_eq({tag, ":zero"}, {63'h0, zero}, {63'h0, (exp_res == 32'h0)});
    check_eq({tag, ":busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
    check_eq({tag, ":busy_at_done"}, {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    check_eq({tag, ":done_pulse"}, {63'h0, done}, 64'h0);
    check_eq({tag, ":res_hold"}, {32'h0, result}, {32'h0, exp_res});
  endtask

  // Independent reference model for the random phase.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] mhi, output logic [31:0] res, output int lat);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 1;
    case (op)
      4'b1100: begin
        p = sa * sb; res = p[31:0]; mhi = p[63:32]; lat = 34;
      end
      4'b0011: begin
        if (b == 32'h0) begin
          res = 32'hFFFF_FFFF; mhi = a;
        end else begin
          q = sa / sb; r = sa % sb; res = q[31:0]; mhi = r[31:0]; lat = 34;
        end
      end
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0110: res = a - b;
      4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: res = (sa > sb) ? 32'd1 : 32'd0;
      4'b1111: res = (a != b) ? 32'd1 : 32'd0;
      4'b1010: res = (sa >= 64'sd0) ? 32'd1 : 32'd0;
      4'b0101: res = {b[15:0], 16'h0000};
      4'b0100: res = b << a[4:0];
      default: res = a + b;
    endcase
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] mhi, mres, ra, rb;
    logic [3:0]  rop;
    int          mlat;
    bit          saw_done;

    rst = 1'b1; start = 1'b0; ctrl = 4'b0000; src1 = 32'h0; src2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst:busy", {63'h0, busy}, 64'h0);
    check_eq("rst:done", {63'h0, done}, 64'h0);
    check_eq("rst:res", {32'h0, result}, 64'h0);
    check_eq("rst:hi", {32'h0, hi}, 64'h0);
    check_eq("rst:zero", {63'h0, zero}, 64'h1);
    rst = 1'b0;

    run_op(4'b0010, 32'd7, 32'hFFFF_FFFE, 1, 32'd5, 32'h0, "add", 1'b0);
    run_op(4'b0110, 32'h1234, 32'h1234, 1, 32'h0, 32'h0, "sub", 1'b0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 32'h0, "slt", 1'b0);
    run_op(4'b0101, 32'h0, 32'h0000_ABCD, 1, 32'hABCD_0000, 32'h0, "lui", 1'b0);
    run_op(4'b1100, 32'hFFFF_FFFD, 32'd7, 34, 32'hFFFF_FFEB, 32'hFFFF_FFFF, "mul", 1'b1);
    run_op(4'b0011, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div", 1'b1);
    run_op(4'b0011, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "div0", 1'b0);

    // Abort a multiply with reset on cycle 10.
    ctrl = 4'b1100; src1 = 32'd1234; src2 = 32'd5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw_done = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort:no_done_before", {63'h0, saw_done}, 64'h0);
    check_eq("abort:busy", {63'h0, busy}, 64'h0);
    check_eq("abort:done", {63'h0, done}, 64'h0);
    check_eq("abort:res", {32'h0, result}, 64'h0);
    check_eq("abort:hi", {32'h0, hi}, 64'h0);
    check_eq("abort:zero", {63'h0, zero}, 64'h1);
    run_op(4'b0001, 32'h0000_00F0, 32'h0000_000F, 1, 32'h0000_00FF, 32'h0, "or_after_rst", 1'b0);

    run_op(4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'h0, "mul_minneg", 1'b0);
    run_op(4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'h0, "div_minneg", 1'b0);
    run_op(4'b0100, 32'h0000_0024, 32'd3, 1, 32'h0000_0030, 32'h0, "sll", 1'b0);
    run_op(4'b1000, 32'd5, 32'hFFFF_FFFF, 1, 32'd1, 32'h0, "sgt", 1'b0);
    run_op(4'b1111, 32'h55AA, 32'h55AA, 1, 32'd0, 32'h0, "sne", 1'b0);
    run_op(4'b1010, 32'h8000_0000, 32'h0, 1, 32'd0, 32'h0, "gez", 1'b0);
    run_op(4'b1001, 32'd40, 32'd2, 1, 32'd42, 32'h0, "undef_add", 1'b0);

    // Back-to-back single-cycle ops, one done pulse per cycle.
    start = 1'b1; ctrl = 4'b0000; src1 = 32'h0000_F0F0; src2 = 32'h0000_FF00;
    @(posedge clk); #1;
    check_eq("b2b0:done", {63'h0, done}, 64'h1);
    check_eq("b2b0:res", {32'h0, result}, {32'h0, 32'h0000_F000});
    ctrl = 4'b0110; src1 = 32'd1; src2 = 32'd2;
    @(posedge clk); #1;
    check_eq("b2b1:done", {63'h0, done}, 64'h1);
    check_eq("b2b1:res", {32'h0, result}, {32'h0, 32'hFFFF_FFFF});
    ctrl = 4'b0010; src1 = 32'd3; src2 = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    check_eq("b2b2:done", {63'h0, done}, 64'h1);
    check_eq("b2b2:res", {32'h0, result}, 64'h0);
    check_eq("b2b2:zero", {63'h0, zero}, 64'h1);
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("b2b:idle", {63'h0, done}, 64'h0);

    mhi = 32'h0;
    for (int k = 0; k < 1000; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra = pick_val();
      rb = pick_val();
      model(rop, ra, rb, mhi, mres, mlat);
      run_op(rop, ra, rb, mlat, mres, mhi, "rnd", ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
